// File: rtl/fd_latch_pkg.sv
// -----------------------------------------------------------------------------
// fd_latch_pkg
// Shared definitions for the IF->ID bundle latch slice.
//   XLEN_DEF     default instruction / PC width
//   INSTR_BYTES  byte stride between consecutive lane PCs
//   MAX_LANES    widest bundle the slice supports
//   fd_bundle_t  reference layout of one fetch bundle at default width
//   bundle_bits  packed width of a bundle for a given lane count / XLEN
// -----------------------------------------------------------------------------
package fd_latch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;
    localparam int MAX_LANES   = 4;

    typedef struct packed {
        logic [MAX_LANES-1:0][XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0]                pc;
        logic [MAX_LANES-1:0]               lane_mask;
    } fd_bundle_t;

    // Storage layout used by the latch: {lane_mask, pc, instr}.
    function automatic int bundle_bits(input int lanes, input int xlen);
        return lanes * xlen + xlen + lanes;
    endfunction

endpackage

// File: rtl/fd_bundle_fifo.sv
// -----------------------------------------------------------------------------
// fd_bundle_fifo
// Generic DEPTH-entry pointer/count FIFO with a synchronous flush.
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   synchronous active-high reset, clears pointers, count, storage
//   flush  in   empties the FIFO next cycle (beats push and pop)
//   push   in   write wdata at the tail (ignored when full)
//   pop    in   advance the head (ignored when empty)
//   wdata  in   WIDTH-bit entry to write
//   rdata  out  WIDTH-bit entry at the head (unqualified; gate with count)
//   count  out  number of stored entries, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module fd_bundle_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // DEPTH is a power of two, so the pointers wrap naturally.
    assign push_ok = push && (count < CW'(DEPTH));
    assign pop_ok  = pop  && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_bundle_latch.sv
// -----------------------------------------------------------------------------
// fetch_decode_bundle_latch
// IF->ID pipeline register carrying LANES-wide fetch bundles through a
// DEPTH-entry elastic buffer, with stall observability.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   FLUSH               drop every buffered bundle (and any offered one)
//   STALL               decode frozen; head is held
//   in_valid/in_ready   fetch-side handshake; in_ready is registered-only
//   in_instr            LANES*XLEN instructions, lane i at [i*XLEN +: XLEN]
//   in_pc               PC of lane 0
//   in_lane_mask        per-lane valid bits; an all-zero mask is not stored
//   out_valid           head bundle present
//   out_instr           head instructions
//   out_lane_pc         head PC + 4*i per lane
//   out_pc_next         head PC + 4*LANES
//   out_lane_mask       head lane mask
//   stall_pc            head PC at the start of the latest stall episode
//   stall_cycles        saturating count of STALL && out_valid cycles
// All head outputs read 0 while out_valid is low.
// -----------------------------------------------------------------------------
module fetch_decode_bundle_latch
    import fd_latch_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  STALL,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [LANES-1:0]      in_lane_mask,
    output logic                  out_valid,
    output logic [LANES*XLEN-1:0] out_instr,
    output logic [LANES*XLEN-1:0] out_lane_pc,
    output logic [XLEN-1:0]       out_pc_next,
    output logic [LANES-1:0]      out_lane_mask,
    output logic [XLEN-1:0]       stall_pc,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int IW = LANES * XLEN;
    localparam int BW = bundle_bits(LANES, XLEN);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BW-1:0]    fifo_wdata;
    logic [BW-1:0]    fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             fifo_push;
    logic             fifo_pop;

    logic [IW-1:0]    head_instr;
    logic [XLEN-1:0]  head_pc;
    logic [LANES-1:0] head_mask;

    logic             stall_hit;
    logic             stall_prev;

    // Handshake. in_ready depends only on the registered count (and RESET),
    // so there is no combinational path from STALL/FLUSH back to fetch.
    assign in_ready  = (fifo_count < CW'(DEPTH)) && !RESET;
    assign out_valid = (fifo_count != '0);

    // An empty-mask bundle completes the handshake but is never stored.
    assign fifo_push  = in_valid && in_ready && !FLUSH && (|in_lane_mask);
    assign fifo_pop   = out_valid && !STALL && !FLUSH;
    assign fifo_wdata = {in_lane_mask, in_pc, in_instr};

    fd_bundle_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .flush (FLUSH),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign head_instr = fifo_rdata[IW-1:0];
    assign head_pc    = fifo_rdata[IW +: XLEN];
    assign head_mask  = fifo_rdata[IW+XLEN +: LANES];

    // Head presentation: lane PCs wrap modulo 2^XLEN; everything reads 0
    // when no bundle is present so decode never sees stale storage.
    always_comb begin
        out_instr     = '0;
        out_lane_pc   = '0;
        out_pc_next   = '0;
        out_lane_mask = '0;
        if (out_valid) begin
            out_instr     = head_instr;
            out_lane_mask = head_mask;
            out_pc_next   = head_pc + XLEN'(INSTR_BYTES * LANES);
            for (int i = 0; i < LANES; i++) begin
                out_lane_pc[i*XLEN +: XLEN] = head_pc + XLEN'(INSTR_BYTES * i);
            end
        end
    end

    // Stall observability. Counting uses out_valid regardless of FLUSH, so a
    // cycle with FLUSH and STALL both high still counts. FLUSH never clears
    // these registers; only RESET does.
    assign stall_hit = STALL && out_valid;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_prev   <= 1'b0;
            stall_pc     <= '0;
            stall_cycles <= '0;
        end else begin
            stall_prev <= stall_hit;
            if (stall_hit && !stall_prev) begin
                stall_pc <= head_pc;
            end
            if (stall_hit && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_bundle_latch.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_bundle_latch
// Scoreboard bench: stimulus pushes the expected head bundle when a stored
// push is issued; a negedge monitor pops and compares on every pop cycle.
// -----------------------------------------------------------------------------
module tb_fetch_decode_bundle_latch;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, STALL, in_valid;
    logic        in_ready, out_valid;
    logic [63:0] in_instr, out_instr, out_lane_pc;
    logic [31:0] in_pc, out_pc_next, stall_pc;
    logic [1:0]  in_lane_mask, out_lane_mask;
    logic [2:0]  stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] instr;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic [63:0] lpc;
        logic [31:0] nxt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    fetch_decode_bundle_latch #(
        .LANES (2),
        .XLEN  (32),
        .DEPTH (2),
        .CNT_W (3)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FLUSH         (FLUSH),
        .STALL         (STALL),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_lane_mask  (in_lane_mask),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_lane_pc   (out_lane_pc),
        .out_pc_next   (out_pc_next),
        .out_lane_mask (out_lane_mask),
        .stall_pc      (stall_pc),
        .stall_cycles  (stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer one bundle for a single cycle; store=1 means it must reach decode.
    task automatic offer(input logic [63:0] instr, input logic [31:0] pc,
                         input logic [1:0] mask, input logic [63:0] lpc,
                         input logic [31:0] nxt, input bit store);
        exp_t e;
        in_valid     = 1'b1;
        in_instr     = instr;
        in_pc        = pc;
        in_lane_mask = mask;
        if (store) begin
            e = '{instr, pc, mask, lpc, nxt};
            q.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: a pop happens at the next rising edge whenever the head is
    // valid and neither STALL nor FLUSH is asserted.
    always @(negedge CLK) begin
        if (RESET || FLUSH) begin
            q.delete();
        end else if (out_valid && !STALL) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_bundle: got head pc %h, required no bundle", out_lane_pc[31:0]);
            end else begin
                mon_e = q.pop_front();
                check("sb_instr",   out_instr,     mon_e.instr);
                check("sb_mask",    out_lane_mask, mon_e.mask);
                check("sb_lane_pc", out_lane_pc,   mon_e.lpc);
                check("sb_pc_next", out_pc_next,   mon_e.nxt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; STALL = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_pc = '0; in_lane_mask = '0;

        // Reset state
        repeat (2) step();
        check("rst_in_ready_low", in_ready, 0);
        check("rst_out_valid",    out_valid, 0);
        RESET = 1'b0;
        #1;
        check("rst_in_ready_high", in_ready, 1);
        check("rst_stall_cycles",  stall_cycles, 0);
        check("rst_stall_pc",      stall_pc, 0);
        check("rst_pc_next",       out_pc_next, 0);

        // Single push, one-cycle latency, lane PCs
        offer(64'hBBBB0002_AAAA0001, 32'h1000, 2'b11, {32'h1004, 32'h1000}, 32'h1008, 1);
        check("lat_out_valid", out_valid, 1);
        repeat (2) step();
        check("lat_drained", out_valid, 0);

        // Stall with three offers into a two-entry buffer
        STALL = 1'b1;
        offer(64'h11110002_11110001, 32'h3000, 2'b11, {32'h3004, 32'h3000}, 32'h3008, 1);
        offer(64'h22220002_22220001, 32'h3010, 2'b01, {32'h3014, 32'h3010}, 32'h3018, 1);
        in_valid = 1'b1; in_instr = 64'h33330002_33330001; in_pc = 32'h3020; in_lane_mask = 2'b10;
        check("stall_full_in_ready", in_ready, 0);
        repeat (4) step();
        check("stall_hold_in_ready", in_ready, 0);
        in_valid = 1'b0;
        STALL = 1'b0;
        check("stall_cycles_5", stall_cycles, 5);
        check("stall_pc_head",  stall_pc, 32'h3000);
        repeat (3) step();
        check("stall_released_empty", out_valid, 0);

        // FLUSH while full with an offered bundle; STALL also high
        STALL = 1'b1;
        offer(64'h44440002_44440001, 32'h4000, 2'b11, {32'h4004, 32'h4000}, 32'h4008, 1);
        offer(64'h55550002_55550001, 32'h4010, 2'b11, {32'h4014, 32'h4010}, 32'h4018, 1);
        in_valid = 1'b1; in_instr = 64'h66660002_66660001; in_pc = 32'h4020; in_lane_mask = 2'b11;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0; in_valid = 1'b0; STALL = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready",  in_ready, 1);
        check("flush_instr0",    out_instr, 0);
        check("flush_lane_pc0",  out_lane_pc, 0);
        check("flush_pc_next0",  out_pc_next, 0);
        check("flush_mask0",     out_lane_mask, 0);
        check("flush_stall_pc",  stall_pc, 32'h4000);
        check("flush_stall_cnt", stall_cycles, 7);
        repeat (2) step();
        check("flush_stays_empty", out_valid, 0);

        // Empty-mask bundle is not stored
        offer(64'h77770002_77770001, 32'h5000, 2'b00, 64'h0, 32'h0, 0);
        check("mask0_not_stored", out_valid, 0);
        offer(64'h88880002_88880001, 32'h2000, 2'b01, {32'h2004, 32'h2000}, 32'h2008, 1);
        repeat (2) step();

        // PC wrap
        offer(64'hCAFE0002_CAFE0001, 32'hFFFFFFFC, 2'b11, {32'h00000000, 32'hFFFFFFFC}, 32'h00000004, 1);
        repeat (2) step();

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h7000 + 32'(16 * i);
            check("tput_in_ready", in_ready, 1);
            offer({32'h9000_0000 + 32'(i), 32'h9100_0000 + 32'(i)}, pc, 2'b11,
                  {pc + 32'd4, pc}, pc + 32'd8, 1);
        end
        repeat (3) step();

        // Saturation with CNT_W=3, survives FLUSH, cleared by RESET
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("sat_reset_clear", stall_cycles, 0);
        STALL = 1'b1;
        offer(64'hABCD0002_ABCD0001, 32'h6000, 2'b11, {32'h6004, 32'h6000}, 32'h6008, 1);
        repeat (10) step();
        check("sat_stall_cycles", stall_cycles, 7);
        check("sat_stall_pc",     stall_pc, 32'h6000);
        STALL = 1'b0;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("sat_after_flush",     stall_cycles, 7);
        check("sat_flush_out_valid", out_valid, 0);
        RESET = 1'b1;
        step();
        check("sat_after_reset",   stall_cycles, 0);
        check("reset_in_ready_lo", in_ready, 0);
        RESET = 1'b0;
        step();

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_bundle_latch.md
# fetch_decode_bundle_latch

Parametrised IF→ID pipeline register that carries multi-lane fetch bundles. It adds three things over a single-instruction latch: a LANES-wide bundle, a DEPTH-entry elastic buffer with a valid/ready handshake, and stall observability (captured stall PC plus a stall-cycle counter). It sits between the fetch stage and decode. FLUSH and STALL keep their pipeline-wide meaning.

## Interface
Parameters:
- LANES, 2: instructions per bundle (1..4).
- XLEN, 32: instruction and PC width.
- DEPTH, 2: buffer entries (power of two, ≥2).
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  discard all buffered bundles.
- STALL  in  1  decode frozen; head is not consumed.
- in_valid  in  1  fetch presents a bundle.
- in_ready  out  1  latch can accept a bundle.
- in_instr  in  LANES*XLEN  lane i at bits [i*XLEN +: XLEN].
- in_pc  in  XLEN  PC of lane 0.
- in_lane_mask  in  LANES  per-lane valid bits.
- out_valid  out  1  head bundle present.
- out_instr  out  LANES*XLEN  head instructions.
- out_lane_pc  out  LANES*XLEN  head PC + 4*i per lane.
- out_pc_next  out  XLEN  head PC + 4*LANES.
- out_lane_mask  out  LANES  head lane mask.
- stall_pc  out  XLEN  head PC at start of the latest stall episode.
- stall_cycles  out  CNT_W  saturating count of stalled-with-valid cycles.

## Operation
- Push: in_valid && in_ready && !FLUSH. A bundle whose in_lane_mask is 0 completes the handshake but is not stored.
- Pop: out_valid && !STALL && !FLUSH.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- in_ready = (count < DEPTH) && !RESET. It is derived only from registered count, with no path from STALL or FLUSH.
- out_valid = (count != 0). When out_valid=0, out_instr, out_lane_pc, out_pc_next and out_lane_mask are all 0.
- FLUSH has priority over push and pop. Next cycle: count=0, pointers=0, out_valid=0. A bundle offered in the flush cycle is dropped.
- Full with simultaneous pop: in_ready is already 0, so there is no same-cycle refill. Full→DEPTH-1, then a push resumes next cycle.
- Empty with push: data is not bypassed; out_valid rises next cycle.
- Stall episode starts on the first cycle with STALL && out_valid after a cycle without it. At that start, stall_pc ← head PC.
- stall_cycles increments on every STALL && out_valid cycle and saturates at 2^CNT_W-1.
- stall_pc and stall_cycles are cleared by RESET only, not by FLUSH.
- PC arithmetic is modulo 2^XLEN. The carry out of +4*i is discarded.
- RESET mid-operation: every register is cleared on that edge, buffered bundles are lost, and in_ready=0 while RESET is high.

## Timing
- Latency: accepted bundle → out_valid one cycle later.
- Throughput: one bundle per cycle in steady state with STALL=0.
- Reset values: in_ready=0 during reset, 1 on the first cycle after; all other outputs 0.
- STALL affects only pop and the stall counters in the same cycle. Buffer contents are unchanged under STALL. Push continues until full.
- FLUSH and STALL both high: FLUSH wins. The stall counter still counts if out_valid was 1 that cycle.

## Structure
- Shared package fd_latch_pkg: XLEN default, INSTR_BYTES=4, and a bundle struct typedef holding instr array, pc and lane_mask.
- Sub-module fd_bundle_fifo: generic DEPTH-entry, pointer/count FIFO with flush. The top level adds lane PC generation, output zeroing and stall observability.

## Test plan
- Reset then one push of pc=0x1000, mask=2'b11, instrs A,B. Required: out_valid one cycle later; out_lane_pc={0x1004,0x1000}; out_pc_next=0x1008.
- STALL held 5 cycles with 3 pushes offered (DEPTH=2). Required: in_ready drops after 2 stored; stall_pc=head PC; stall_cycles=5; order preserved on release.
- FLUSH while full and in_valid=1. Required: next cycle out_valid=0, in_ready=1, all outputs 0, offered bundle absent.
- Push with mask=0 followed by pc=0x2000. Required: only the 0x2000 bundle appears at the output.
- in_pc=0xFFFFFFFC, LANES=2. Required: out_lane_pc lane1=0x0, out_pc_next=0x4.
- CNT_W=3 with a 10-cycle stall. Required: stall_cycles saturates at 7. A later FLUSH leaves it at 7; RESET clears it to 0.
